// File: rtl/bios_block_sink_if.sv
// Loader and memory-port signals of the BIOS block sink, bundled for port connection.
// The slave side is the sink itself; the master side is the loader/memory environment.
interface bios_block_sink_if #(
    parameter int DW  = 16,
    parameter int MAW = 20,
    parameter int CW  = 7
);
    logic           bios_wr;
    logic [DW-1:0]  bios_din;
    logic           bios_req;
    logic [MAW-1:0] mem_addr;
    logic [DW-1:0]  mem_dout;
    logic           mem_we;
    logic           mem_ready;
    logic           done;
    logic [CW-1:0]  block_cnt;
    logic           err;

    modport slave (
        input  bios_wr, bios_din, mem_ready,
        output bios_req, mem_addr, mem_dout, mem_we, done, block_cnt, err
    );

    modport master (
        output bios_wr, bios_din, mem_ready,
        input  bios_req, mem_addr, mem_dout, mem_we, done, block_cnt, err
    );
endinterface

// File: rtl/bios_block_sink.sv
// Pulls BIOS blocks from the loader into a local buffer, then streams each block into
// system memory; done is raised once the whole image has been written.
module bios_block_sink #(
    parameter int             DW          = 16,
    parameter int             MAW         = 20,
    parameter int             BLOCK_WORDS = 64,
    parameter int             TOTAL_WORDS = 4096,
    parameter logic [MAW-1:0] BASE_ADDR   = 20'hFE000
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    bios_block_sink_if.slave bus
);
    localparam int NBLK = TOTAL_WORDS / BLOCK_WORDS;
    localparam int CW   = $clog2(NBLK) + 1;
    localparam int IW   = $clog2(BLOCK_WORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(BLOCK_WORDS - 1);
    localparam logic [CW-1:0] LAST_BLK = CW'(NBLK - 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_TAIL, S_ACK, S_WRITE, S_DONE} state_t;

    state_t         r_state;
    logic           r_req, r_cap_pend, r_we, r_done, r_err;
    logic [IW-1:0]  r_req_cnt, r_cap_idx, r_idx;
    logic [MAW-1:0] r_addr;
    logic [DW-1:0]  r_dout;
    logic [CW-1:0]  r_blk;
    logic [DW-1:0]  r_buf [BLOCK_WORDS];

    logic           w_cap;
    logic [IW-1:0]  w_rd_idx;
    logic [DW-1:0]  w_rd_data;
    logic [MAW-1:0] w_base;

    // The next word is read combinationally so back-to-back accepts need no bubble.
    always_comb begin
        w_cap     = r_cap_pend && (r_state == S_REQ || r_state == S_TAIL);
        w_rd_idx  = (r_state == S_WRITE) ? r_idx + IW'(1) : '0;
        w_rd_data = r_buf[w_rd_idx];
        w_base    = BASE_ADDR + MAW'(r_blk) * MAW'(BLOCK_WORDS);
    end

    always_ff @(posedge clk_sys) begin
        if (w_cap) r_buf[r_cap_idx] <= bus.bios_din;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_req      <= 1'b0;
            r_cap_pend <= 1'b0;
            r_we       <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_req_cnt  <= '0;
            r_cap_idx  <= '0;
            r_idx      <= '0;
            r_addr     <= '0;
            r_dout     <= '0;
            r_blk      <= '0;
        end else begin
            // Loader data lags each request by one cycle.
            r_cap_pend <= r_req;
            if (w_cap) r_cap_idx <= r_cap_idx + 1'b1;
            case (r_state)
                S_IDLE: if (bus.bios_wr) begin
                    r_state   <= S_REQ;
                    r_req     <= 1'b1;
                    r_req_cnt <= '0;
                    r_cap_idx <= '0;
                    r_idx     <= '0;
                end
                S_REQ: begin
                    if (!bus.bios_wr) begin
                        r_err   <= 1'b1;
                        r_req   <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_req_cnt == LAST_IDX) begin
                        r_req   <= 1'b0;
                        r_state <= S_TAIL;
                    end else begin
                        r_req_cnt <= r_req_cnt + 1'b1;
                    end
                end
                S_TAIL: r_state <= S_ACK;
                S_ACK: if (!bus.bios_wr) begin
                    r_state <= S_WRITE;
                    r_we    <= 1'b1;
                    r_idx   <= '0;
                    r_addr  <= w_base;
                    r_dout  <= w_rd_data;
                end
                S_WRITE: if (bus.mem_ready) begin
                    if (r_idx == LAST_IDX) begin
                        r_we  <= 1'b0;
                        r_blk <= r_blk + 1'b1;
                        if (r_blk == LAST_BLK) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_idx  <= r_idx + 1'b1;
                        r_addr <= r_addr + 1'b1;
                        r_dout <= w_rd_data;
                    end
                end
                S_DONE:  r_done  <= 1'b1;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.bios_req  = r_req;
    assign bus.mem_we    = r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_dout  = r_dout;
    assign bus.done      = r_done;
    assign bus.block_cnt = r_blk;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_bios_block_sink.sv
// Randomized scoreboard bench for bios_block_sink: a loader model feeds blocks, the expected
// memory writes are queued up front and a negedge monitor pops them as the sink writes.
module tb_bios_block_sink;
    localparam int          BW   = 64;
    localparam int          NBLK = 64;
    localparam logic [19:0] BASE = 20'hFE000;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;

    bios_block_sink_if #(.DW(16), .MAW(20), .CW(7)) bus();
    bios_block_sink dut (.clk_sys(clk_sys), .reset_n(reset_n), .bus(bus));

    always #5 clk_sys = ~clk_sys;

    typedef struct packed { logic [19:0] addr; logic [15:0] data; } wr_t;
    wr_t exp_q[$];
    int  total = 0, bad = 0, acc_cnt = 0, exp_blk = 0, rdy_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] wdata(input bit a000, input int k);
        return a000 ? 16'hA000 + 16'(k) : 16'(exp_blk * BW + k);
    endfunction

    task automatic rst_check();
        chk("rst_req",   32'(bus.bios_req),  0);
        chk("rst_we",    32'(bus.mem_we),    0);
        chk("rst_addr",  32'(bus.mem_addr),  0);
        chk("rst_dout",  32'(bus.mem_dout),  0);
        chk("rst_done",  32'(bus.done),      0);
        chk("rst_blk",   32'(bus.block_cnt), 0);
        chk("rst_err",   32'(bus.err),       0);
    endtask

    // Loader model: one word returned the cycle after each request-high cycle.
    task automatic burst(input int abort_at, input int hold, input bit a000);
        int k, nreq, guard;
        bit prev, seen;
        k = 0; nreq = 0; guard = 0; prev = 0; seen = 0;
        if (abort_at == 0)
            for (int i = 0; i < BW; i++)
                exp_q.push_back('{addr: BASE + 20'(exp_blk * BW + i), data: wdata(a000, i)});
        @(posedge clk_sys); #1;
        bus.bios_wr = 1'b1;
        while (guard < 200) begin
            @(posedge clk_sys); #1;
            guard++;
            if (prev) begin
                bus.bios_din = wdata(a000, k);
                k++;
            end
            prev = bus.bios_req;
            if (bus.bios_req) begin
                nreq++;
                seen = 1;
                if (nreq == abort_at) begin
                    bus.bios_wr = 1'b0;
                    break;
                end
            end else if (seen) begin
                break;
            end
        end
        if (abort_at == 0) begin
            chk("req_cycles", 32'(nreq), 64);
            for (int i = 0; i < hold; i++) begin
                chk("ack_hold_we", 32'(bus.mem_we), 0);
                @(posedge clk_sys); #1;
            end
            bus.bios_wr = 1'b0;
        end
    endtask

    task automatic finish_block();
        int guard;
        guard = 0;
        do begin
            @(posedge clk_sys); #1;
            guard++;
        end while ((exp_q.size() != 0 || bus.mem_we) && guard < 3000);
        chk("write_timeout", 32'(guard < 3000), 1);
        exp_blk++;
        chk("block_cnt", 32'(bus.block_cnt), 32'(exp_blk));
    endtask

    // mem_ready driver: 0 = always ready, 1 = 1,0,0 pattern, 2 = random
    initial begin
        int ph;
        ph = 0;
        bus.mem_ready = 1'b1;
        forever begin
            @(posedge clk_sys); #1;
            case (rdy_mode)
                1: begin bus.mem_ready = (ph == 0); ph = (ph + 1) % 3; end
                2: bus.mem_ready = 1'($urandom_range(0, 1));
                default: bus.mem_ready = 1'b1;
            endcase
        end
    end

    // Monitor: a write is accepted on the next rising edge when we and ready are both high.
    initial begin
        logic        hold_v;
        logic [19:0] h_addr;
        logic [15:0] h_data;
        wr_t         e;
        hold_v = 0; h_addr = '0; h_data = '0;
        forever begin
            @(negedge clk_sys);
            if (!reset_n) begin
                hold_v = 0;
            end else begin
                if (bus.bios_req || bus.mem_we)
                    chk("req_we_excl", 32'(bus.bios_req & bus.mem_we), 0);
                if (hold_v && bus.mem_we) begin
                    chk("stall_addr", 32'(bus.mem_addr), 32'(h_addr));
                    chk("stall_data", 32'(bus.mem_dout), 32'(h_data));
                end
                hold_v = bus.mem_we && !bus.mem_ready;
                h_addr = bus.mem_addr;
                h_data = bus.mem_dout;
                if (bus.mem_we && bus.mem_ready) begin
                    acc_cnt++;
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL extra_write: addr %0h data %0h with nothing expected",
                                 bus.mem_addr, bus.mem_dout);
                    end else begin
                        total--;
                        e = exp_q.pop_front();
                        chk("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
                        chk("wr_data", 32'(bus.mem_dout), 32'(e.data));
                    end
                end
            end
        end
    end

    initial begin
        int g;
        bus.bios_wr = 1'b0;
        bus.bios_din = '0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1 rst_check();
        @(negedge clk_sys) reset_n = 1'b1;

        // single burst, A000+k data, memory always ready
        rdy_mode = 0;
        burst(0, 0, 1'b1);
        finish_block();
        chk("single_err", 32'(bus.err), 0);

        // reset in the middle of a block write (idx=10)
        acc_cnt = 0;
        burst(0, 0, 1'b0);
        g = 0;
        while (acc_cnt < 10 && g < 500) begin
            @(posedge clk_sys); #2;
            g++;
        end
        chk("mid_write_idx", 32'(acc_cnt), 10);
        reset_n = 1'b0;
        #1 rst_check();
        exp_q.delete();
        exp_blk = 0;
        @(negedge clk_sys) reset_n = 1'b1;
        repeat (5) begin
            @(posedge clk_sys); #1;
            chk("post_rst_req", 32'(bus.bios_req), 0);
            chk("post_rst_we",  32'(bus.mem_we),   0);
        end

        // abort on the 20th request cycle
        rdy_mode = 2;
        burst(20, 0, 1'b0);
        @(posedge clk_sys); #1;
        chk("abort_req_low", 32'(bus.bios_req), 0);
        chk("abort_err",     32'(bus.err),      1);
        repeat (10) begin
            @(posedge clk_sys); #1;
            chk("abort_no_we", 32'(bus.mem_we), 0);
        end
        chk("abort_blk", 32'(bus.block_cnt), 0);

        // block 0 again after the abort, then a stalled block and an ACK-hold block
        burst(0, 0, 1'b0);
        finish_block();
        rdy_mode = 1;
        burst(0, 0, 1'b0);
        finish_block();
        rdy_mode = 2;
        burst(0, 10, 1'b0);
        finish_block();

        // rest of the image
        while (exp_blk < NBLK) begin
            rdy_mode = int'($urandom_range(0, 2));
            repeat ($urandom_range(0, 3)) @(posedge clk_sys);
            if (exp_blk == NBLK - 1) chk("done_early", 32'(bus.done), 0);
            burst(0, 0, 1'b0);
            finish_block();
        end
        chk("done",       32'(bus.done),      1);
        chk("final_blk",  32'(bus.block_cnt), 64);
        chk("err_sticky", 32'(bus.err),       1);

        // loader pulse after completion is ignored
        @(posedge clk_sys); #1 bus.bios_wr = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1 bus.bios_wr = 1'b0;
        repeat (20) begin
            @(posedge clk_sys); #1;
            chk("done_no_req", 32'(bus.bios_req), 0);
            chk("done_no_we",  32'(bus.mem_we),   0);
        end
        chk("done_held", 32'(bus.done), 1);
        chk("queue_empty", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bios_block_sink.md
Name: bios_block_sink

Overview:
System-side receiver for the BIOS block-transfer interface. When the loader flags a ready 64-word block (bios_wr), this block pulls the words in with bios_req and holds them in a local buffer. It then writes the block into system memory through a ready-gated write port. It lives inside the Next186 system next to the memory controller, and raises done once the full BIOS image is stored, which releases the CPU from boot hold.

Parameters:
DW, 16, data word width
MAW, 20, memory word-address width
BLOCK_WORDS, 64, words per burst (power of two)
TOTAL_WORDS, 4096, words in the complete BIOS image (multiple of BLOCK_WORDS)
BASE_ADDR, 20'hFE000, memory word address of BIOS word 0

Ports:
clk_sys  in  1  system clock; all logic on the rising edge
reset_n  in  1  asynchronous, active-low reset
bios_wr  in  1  loader has a full block staged; stays high until the loader sees bios_req fall
bios_din  in  DW  loader data; valid the cycle after each bios_req-high cycle
bios_req  out  1  word request strobe, one word per high cycle
mem_addr  out  MAW  memory write address
mem_dout  out  DW  memory write data
mem_we  out  1  write request
mem_ready  in  1  memory accepts the current write on an edge where mem_we=1 and mem_ready=1
done  out  1  full image stored; sticky
block_cnt  out  log2(TOTAL_WORDS/BLOCK_WORDS)+1  blocks completed
err  out  1  sticky protocol error

Behaviour:
- Reset (async, reset_n=0): state=IDLE; bios_req=0, mem_we=0, mem_addr=0, mem_dout=0, done=0, block_cnt=0, err=0; word index=0. Buffer contents are don't-care.
- States: IDLE, REQ, TAIL, ACK, WRITE, DONE.
- IDLE: when bios_wr=1, go to REQ and set idx=0.
- REQ: bios_req=1 for exactly BLOCK_WORDS consecutive cycles, counted by a request counter.
  - Capture is delayed one cycle: on each cycle after a req-high cycle, bios_din goes into buf[cap_idx] and cap_idx increments.
  - When the last request issues, go to TAIL (bios_req=0).
- TAIL: one cycle; capture the final word (cap_idx=BLOCK_WORDS-1), then go to ACK.
- ACK: wait for bios_wr=0, then go to WRITE with idx=0.
- WRITE:
  - mem_we=1, mem_addr=BASE_ADDR+block_cnt*BLOCK_WORDS+idx, mem_dout=buf[idx].
  - Hold all three stable until an edge with mem_ready=1, then idx++.
  - After the edge that accepts idx=BLOCK_WORDS-1: mem_we=0, block_cnt++. If block_cnt reaches TOTAL_WORDS/BLOCK_WORDS go to DONE, else go to IDLE.
  - Minimum one word per cycle when mem_ready is held high: buffer read must be combinational or pre-fetched so there are no bubbles.
- DONE: done=1; bios_req=0 and mem_we=0 permanently; bios_wr is ignored. Leave only on reset.
- Errors:
  - bios_wr=0 on any REQ cycle: set err=1 and abort. bios_req drops the next cycle, the partial buffer is discarded, block_cnt is unchanged, go to IDLE.
  - bios_wr re-asserted while in WRITE: ignored. It is serviced from IDLE after the write completes.
- Address arithmetic wraps modulo 2^MAW; no overflow flag.
- Latency with mem_ready tied high, from bios_wr rise to the first mem_we:
  - IDLE→REQ: 1 cycle
  - REQ: BLOCK_WORDS cycles
  - TAIL: 1 cycle
  - ACK: ≥1 cycle
  - In total, 67 cycles minimum at the defaults.
- bios_req and mem_we are registered outputs and are never high in the same cycle.

Test Plan:
- Reset state: reset_n=0 mid-WRITE (idx=10) → on the same cycle every output is 0; after release the block stays in IDLE until bios_wr rises.
- Single burst:
  - Stimulus: bios_wr=1; loader returns word k = 16'hA000+k the cycle after each request; mem_ready=1.
  - Required: bios_req high for exactly 64 cycles; 64 writes to addresses 0xFE000–0xFE03F with data A000–A03F; block_cnt=1.
- Memory stall: mem_ready pattern 1,0,0,1,… during WRITE → mem_addr/mem_dout held through stall cycles; every word written exactly once in order; no dropped words.
- Full image:
  - Stimulus: 64 back-to-back bursts carrying data = global word index.
  - Required: done rises after the last write to 0xFEFFF; block_cnt=64; a later bios_wr pulse produces no bios_req.
- Abort: bios_wr dropped on the 20th req cycle → err=1; bios_req low the next cycle; no mem_we; block_cnt unchanged; the next full burst still writes the correct block 0 addresses.
- ACK hold: bios_wr kept high 10 cycles after the burst → the block stays in ACK with mem_we=0 until bios_wr falls, then writes normally.
